// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station feeding the integer ALU
// Optional macro RS_OLDEST_FIRST_EN: issue the oldest ready entry instead of the lowest index.
module reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 DP_sgn,
  input  logic [5:0]           DP_opcode,
  input  logic [ROB_WIDTH-1:0] DP_ROB_name,
  input  logic [31:0]          DP_Vj,
  input  logic [31:0]          DP_Vk,
  input  logic                 DP_Qj_busy,
  input  logic                 DP_Qk_busy,
  input  logic [ROB_WIDTH-1:0] DP_Qj,
  input  logic [ROB_WIDTH-1:0] DP_Qk,
  output logic                 RS_full,
  input  logic                 ALU_CDB_sgn,
  input  logic [ROB_WIDTH-1:0] ALU_CDB_ROB_name,
  input  logic [31:0]          ALU_CDB_result,
  input  logic                 LSB_CDB_sgn,
  input  logic [ROB_WIDTH-1:0] LSB_CDB_ROB_name,
  input  logic [31:0]          LSB_CDB_result,
  output logic                 ALU_sgn,
  output logic [5:0]           ALU_opcode,
  output logic [ROB_WIDTH-1:0] ALU_ROB_name,
  output logic [31:0]          ALU_lhs,
  output logic [31:0]          ALU_rhs
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   r_busy;
  logic [RS_SIZE-1:0]   r_qj_busy;
  logic [RS_SIZE-1:0]   r_qk_busy;
  logic [5:0]           r_opcode [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_rob    [RS_SIZE];
  logic [31:0]          r_vj     [RS_SIZE];
  logic [31:0]          r_vk     [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qj     [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qk     [RS_SIZE];

  logic [RS_SIZE-1:0] w_ready;
  logic               w_free_found;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_issue_found;
  logic [IDX_W-1:0]   w_issue_idx;
  logic [31:0]        w_dp_vj;
  logic [31:0]        w_dp_vk;
  logic               w_dp_qj_busy;
  logic               w_dp_qk_busy;

`ifdef RS_OLDEST_FIRST_EN
  localparam int SEQ_W = ROB_WIDTH + 1;
  logic [SEQ_W-1:0] r_seq [RS_SIZE];
  logic [SEQ_W-1:0] r_seq_cnt;
  logic [SEQ_W-1:0] w_age_diff;
`endif

  assign RS_full = &r_busy;

  always_comb begin
    w_ready      = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] & ~r_qj_busy[i] & ~r_qk_busy[i];
    end
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_issue_found = 1'b0;
    w_issue_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    w_age_diff = '0;
    // Wrap-safe age compare: candidate is older when (cand - best) is negative.
    for (int i = 0; i < RS_SIZE; i++) begin
      w_age_diff = r_seq[i] - r_seq[w_issue_idx];
      if (w_ready[i] && (!w_issue_found || w_age_diff[SEQ_W-1])) begin
        w_issue_found = 1'b1;
        w_issue_idx   = IDX_W'(i);
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_issue_found = 1'b1;
        w_issue_idx   = IDX_W'(i);
      end
    end
`endif
  end

  // Dispatch bypass: a CDB broadcast in the dispatch cycle resolves the operand directly.
  always_comb begin
    w_dp_vj      = DP_Vj;
    w_dp_qj_busy = DP_Qj_busy;
    w_dp_vk      = DP_Vk;
    w_dp_qk_busy = DP_Qk_busy;
    if (DP_Qj_busy && ALU_CDB_sgn && ALU_CDB_ROB_name == DP_Qj) begin
      w_dp_vj      = ALU_CDB_result;
      w_dp_qj_busy = 1'b0;
    end else if (DP_Qj_busy && LSB_CDB_sgn && LSB_CDB_ROB_name == DP_Qj) begin
      w_dp_vj      = LSB_CDB_result;
      w_dp_qj_busy = 1'b0;
    end
    if (DP_Qk_busy && ALU_CDB_sgn && ALU_CDB_ROB_name == DP_Qk) begin
      w_dp_vk      = ALU_CDB_result;
      w_dp_qk_busy = 1'b0;
    end else if (DP_Qk_busy && LSB_CDB_sgn && LSB_CDB_ROB_name == DP_Qk) begin
      w_dp_vk      = LSB_CDB_result;
      w_dp_qk_busy = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy       <= '0;
      r_qj_busy    <= '0;
      r_qk_busy    <= '0;
      ALU_sgn      <= 1'b0;
      ALU_opcode   <= '0;
      ALU_ROB_name <= '0;
      ALU_lhs      <= '0;
      ALU_rhs      <= '0;
    end else if (clear) begin
      r_busy  <= '0;
      ALU_sgn <= 1'b0;
    end else if (!rdy) begin
      ALU_sgn <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_qj_busy[i]) begin
          if (ALU_CDB_sgn && ALU_CDB_ROB_name == r_qj[i]) begin
            r_vj[i]      <= ALU_CDB_result;
            r_qj_busy[i] <= 1'b0;
          end else if (LSB_CDB_sgn && LSB_CDB_ROB_name == r_qj[i]) begin
            r_vj[i]      <= LSB_CDB_result;
            r_qj_busy[i] <= 1'b0;
          end
        end
        if (r_busy[i] && r_qk_busy[i]) begin
          if (ALU_CDB_sgn && ALU_CDB_ROB_name == r_qk[i]) begin
            r_vk[i]      <= ALU_CDB_result;
            r_qk_busy[i] <= 1'b0;
          end else if (LSB_CDB_sgn && LSB_CDB_ROB_name == r_qk[i]) begin
            r_vk[i]      <= LSB_CDB_result;
            r_qk_busy[i] <= 1'b0;
          end
        end
      end
      ALU_sgn <= w_issue_found;
      if (w_issue_found) begin
        r_busy[w_issue_idx] <= 1'b0;
        ALU_opcode          <= r_opcode[w_issue_idx];
        ALU_ROB_name        <= r_rob[w_issue_idx];
        ALU_lhs             <= r_vj[w_issue_idx];
        ALU_rhs             <= r_vk[w_issue_idx];
      end
      // The free slot is never busy, so it cannot collide with issue or wakeup.
      if (DP_sgn && w_free_found) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_opcode[w_free_idx]  <= DP_opcode;
        r_rob[w_free_idx]     <= DP_ROB_name;
        r_vj[w_free_idx]      <= w_dp_vj;
        r_vk[w_free_idx]      <= w_dp_vk;
        r_qj_busy[w_free_idx] <= w_dp_qj_busy;
        r_qk_busy[w_free_idx] <= w_dp_qk_busy;
        r_qj[w_free_idx]      <= DP_Qj;
        r_qk[w_free_idx]      <= DP_Qk;
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_seq_cnt <= '0;
    end else if (rdy && DP_sgn && w_free_found) begin
      r_seq[w_free_idx] <= r_seq_cnt;
      r_seq_cnt         <= r_seq_cnt + SEQ_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed bench for reservation_station with a behavioural model
module tb_reservation_station;
  localparam int N = 16;
`ifdef RS_OLDEST_FIRST_EN
  localparam bit OLDEST = 1'b1;
`else
  localparam bit OLDEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rdy, clear;
  logic DP_sgn, DP_Qj_busy, DP_Qk_busy;
  logic [5:0] DP_opcode;
  logic [3:0] DP_ROB_name, DP_Qj, DP_Qk;
  logic [31:0] DP_Vj, DP_Vk;
  logic RS_full;
  logic ALU_CDB_sgn, LSB_CDB_sgn;
  logic [3:0] ALU_CDB_ROB_name, LSB_CDB_ROB_name;
  logic [31:0] ALU_CDB_result, LSB_CDB_result;
  logic ALU_sgn;
  logic [5:0] ALU_opcode;
  logic [3:0] ALU_ROB_name;
  logic [31:0] ALU_lhs, ALU_rhs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reservation_station #(.RS_SIZE(N), .ROB_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .DP_sgn(DP_sgn), .DP_opcode(DP_opcode), .DP_ROB_name(DP_ROB_name),
    .DP_Vj(DP_Vj), .DP_Vk(DP_Vk), .DP_Qj_busy(DP_Qj_busy), .DP_Qk_busy(DP_Qk_busy),
    .DP_Qj(DP_Qj), .DP_Qk(DP_Qk), .RS_full(RS_full),
    .ALU_CDB_sgn(ALU_CDB_sgn), .ALU_CDB_ROB_name(ALU_CDB_ROB_name), .ALU_CDB_result(ALU_CDB_result),
    .LSB_CDB_sgn(LSB_CDB_sgn), .LSB_CDB_ROB_name(LSB_CDB_ROB_name), .LSB_CDB_result(LSB_CDB_result),
    .ALU_sgn(ALU_sgn), .ALU_opcode(ALU_opcode), .ALU_ROB_name(ALU_ROB_name),
    .ALU_lhs(ALU_lhs), .ALU_rhs(ALU_rhs)
  );

  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [3:0]  tag;
    logic [31:0] vj, vk;
    bit          pj, pk;
    logic [3:0]  qj, qk;
    int          seq;
  } ent_t;

  ent_t m [N];
  int   m_seq = 0;
  bit   e_sgn = 1'b0;
  logic [5:0]  e_op;
  logic [3:0]  e_tag;
  logic [31:0] e_lhs, e_rhs;

  // Snoop both CDBs for one pending operand; the ALU bus has priority.
  task automatic snoop(inout bit p, input logic [3:0] q, inout logic [31:0] v);
    if (p && ALU_CDB_sgn && ALU_CDB_ROB_name == q) begin
      v = ALU_CDB_result; p = 1'b0;
    end else if (p && LSB_CDB_sgn && LSB_CDB_ROB_name == q) begin
      v = LSB_CDB_result; p = 1'b0;
    end
  endtask

  task automatic model_edge();
    ent_t nx [N];
    int sel, fre;
    nx = m;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin nx[i].busy = 0; nx[i].pj = 0; nx[i].pk = 0; end
      e_sgn = 0; e_op = 0; e_tag = 0; e_lhs = 0; e_rhs = 0; m_seq = 0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) nx[i].busy = 0;
      e_sgn = 0; m_seq = 0;
    end else if (!rdy) begin
      e_sgn = 0;
    end else begin
      sel = -1;
      for (int i = 0; i < N; i++)
        if (m[i].busy && !m[i].pj && !m[i].pk)
          if (sel < 0 || (OLDEST && m[i].seq < m[sel].seq)) sel = i;
      fre = -1;
      for (int i = 0; i < N; i++) if (!m[i].busy && fre < 0) fre = i;
      if (DP_sgn && fre >= 0) begin
        nx[fre].busy = 1; nx[fre].op = DP_opcode; nx[fre].tag = DP_ROB_name;
        nx[fre].vj = DP_Vj; nx[fre].vk = DP_Vk; nx[fre].pj = DP_Qj_busy; nx[fre].pk = DP_Qk_busy;
        nx[fre].qj = DP_Qj; nx[fre].qk = DP_Qk; nx[fre].seq = m_seq; m_seq++;
      end
      for (int i = 0; i < N; i++) if (nx[i].busy) begin
        snoop(nx[i].pj, nx[i].qj, nx[i].vj);
        snoop(nx[i].pk, nx[i].qk, nx[i].vk);
      end
      e_sgn = (sel >= 0);
      if (sel >= 0) begin
        nx[sel].busy = 0;
        e_op = m[sel].op; e_tag = m[sel].tag; e_lhs = m[sel].vj; e_rhs = m[sel].vk;
      end
    end
    m = nx;
  endtask

  task automatic compare();
    int cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m[i].busy);
    checks++;
    if (ALU_sgn !== e_sgn) begin
      failures++;
      $display("FAIL model_sgn t=%0t actual=%0b expected=%0b", $time, ALU_sgn, e_sgn);
    end
    if (e_sgn) begin
      checks++;
      if ({ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs} !== {e_op, e_tag, e_lhs, e_rhs}) begin
        failures++;
        $display("FAIL model_issue t=%0t actual=op%0h tag%0h lhs%0h rhs%0h expected=op%0h tag%0h lhs%0h rhs%0h",
                 $time, ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs, e_op, e_tag, e_lhs, e_rhs);
      end
    end
    checks++;
    if (RS_full !== (cnt == N)) begin
      failures++;
      $display("FAIL model_full t=%0t actual=%0b expected=%0b", $time, RS_full, (cnt == N));
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare();
    DP_sgn = 0; ALU_CDB_sgn = 0; LSB_CDB_sgn = 0; clear = 0;
  endtask

  task automatic dp(input logic [5:0] op, input logic [3:0] tag, input logic [31:0] vj, input logic [31:0] vk,
                    input logic pj, input logic [3:0] qj, input logic pk, input logic [3:0] qk);
    DP_sgn = 1; DP_opcode = op; DP_ROB_name = tag; DP_Vj = vj; DP_Vk = vk;
    DP_Qj_busy = pj; DP_Qj = qj; DP_Qk_busy = pk; DP_Qk = qk;
  endtask

  task automatic acdb(input logic [3:0] tag, input logic [31:0] val);
    ALU_CDB_sgn = 1; ALU_CDB_ROB_name = tag; ALU_CDB_result = val;
  endtask

  task automatic lcdb(input logic [3:0] tag, input logic [31:0] val);
    LSB_CDB_sgn = 1; LSB_CDB_ROB_name = tag; LSB_CDB_result = val;
  endtask

  initial begin
    rst = 0; rdy = 1; clear = 0;
    DP_sgn = 0; DP_opcode = 0; DP_ROB_name = 0; DP_Vj = 0; DP_Vk = 0;
    DP_Qj_busy = 0; DP_Qk_busy = 0; DP_Qj = 0; DP_Qk = 0;
    ALU_CDB_sgn = 0; ALU_CDB_ROB_name = 0; ALU_CDB_result = 0;
    LSB_CDB_sgn = 0; LSB_CDB_ROB_name = 0; LSB_CDB_result = 0;

    // Reset, then a dispatch with both operands pending never issues
    tick(); tick();
    lit("reset_sgn", 32'(ALU_sgn), 0);
    lit("reset_full", 32'(RS_full), 0);
    rst = 1;
    dp(6'd1, 4'd1, 0, 0, 1, 4'd7, 1, 4'd7); tick(); tick(); tick();
    lit("pending_no_issue", 32'(ALU_sgn), 0);
    clear = 1; tick();

    // Ready dispatch: strobe exactly one cycle, two edges after dispatch
    dp(6'd1, 4'd2, 32'd5, 32'd7, 0, 0, 0, 0); tick();
    lit("ready_not_yet", 32'(ALU_sgn), 0);
    tick();
    lit("ready_sgn", 32'(ALU_sgn), 1);
    lit("ready_lhs", ALU_lhs, 5);
    lit("ready_rhs", ALU_rhs, 7);
    lit("ready_tag", 32'(ALU_ROB_name), 2);
    tick();
    lit("ready_one_shot", 32'(ALU_sgn), 0);

    // Wakeup via ALU CDB, then via LSB CDB
    dp(6'd2, 4'd5, 0, 32'd1, 1, 4'd3, 0, 0); tick(); tick();
    acdb(4'd3, 32'h10); tick();
    lit("alu_wake_same_edge", 32'(ALU_sgn), 0);
    tick();
    lit("alu_wake_lhs", ALU_lhs, 32'h10);
    lit("alu_wake_rhs", ALU_rhs, 1);
    dp(6'd2, 4'd6, 0, 32'd1, 1, 4'd3, 0, 0); tick(); tick();
    lcdb(4'd3, 32'h10); tick(); tick();
    lit("lsb_wake_lhs", ALU_lhs, 32'h10);
    lit("lsb_wake_tag", 32'(ALU_ROB_name), 6);

    // Tag 0 is legal, on the Qk side
    dp(6'd3, 4'd7, 32'd2, 0, 0, 0, 1, 4'd0); tick();
    acdb(4'd0, 32'h77); tick(); tick();
    lit("tag0_rhs", ALU_rhs, 32'h77);

    // Same-cycle bypass, LSB only and then both buses (ALU wins)
    dp(6'd4, 4'd8, 0, 32'd3, 1, 4'd4, 0, 0); lcdb(4'd4, 32'hFF); tick(); tick();
    lit("bypass_lhs", ALU_lhs, 32'hFF);
    dp(6'd4, 4'd8, 0, 32'd3, 1, 4'd4, 0, 0); lcdb(4'd4, 32'hFF); acdb(4'd4, 32'hAA); tick(); tick();
    lit("bypass_alu_wins", ALU_lhs, 32'hAA);
    tick();

    // Fill, ignored overflow dispatch, drain, clear mid-drain
    for (int i = 0; i < N; i++) begin
      dp(6'd5, 4'(i), 32'hDEAD, 32'(i), 1, 4'd9, 0, 0); tick();
    end
    lit("full_set", 32'(RS_full), 1);
    dp(6'd5, 4'd15, 0, 32'd99, 0, 0, 0, 0); tick();
    lit("full_ignored_no_issue", 32'(ALU_sgn), 0);
    acdb(4'd9, 32'h99); tick(); tick();
    lit("drain0_rhs", ALU_rhs, 0);
    lit("drain0_lhs", ALU_lhs, 32'h99);
    lit("drain0_full_drop", 32'(RS_full), 0);
    tick();
    lit("drain1_rhs", ALU_rhs, 1);
    clear = 1; tick();
    lit("clear_sgn", 32'(ALU_sgn), 0);
    lit("clear_full", 32'(RS_full), 0);
    tick(); tick();
    lit("clear_no_more", 32'(ALU_sgn), 0);

    // rdy freeze holds a ready entry for three cycles
    dp(6'd6, 4'd1, 32'hA, 32'hB, 0, 0, 0, 0); tick();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("freeze_sgn", 32'(ALU_sgn), 0);
    end
    rdy = 1; tick();
    lit("unfreeze_sgn", 32'(ALU_sgn), 1);
    lit("unfreeze_lhs", ALU_lhs, 32'hA);
    lit("unfreeze_rhs", ALU_rhs, 32'hB);
    tick();

    // Place an older entry at index 3 and a younger one at index 1
    dp(6'd7, 4'd0, 0, 0, 1, 4'd12, 0, 0); tick();
    dp(6'd7, 4'd1, 0, 0, 1, 4'd13, 0, 0); tick();
    dp(6'd7, 4'd2, 0, 0, 1, 4'd12, 0, 0); tick();
    dp(6'd7, 4'd3, 0, 0, 1, 4'd14, 0, 0); tick();
    acdb(4'd14, 32'h1); tick(); tick();
    lit("order_free3_tag", 32'(ALU_ROB_name), 3);
    dp(6'd7, 4'd4, 0, 32'h44, 1, 4'd15, 0, 0); tick();
    lcdb(4'd13, 32'h2); tick(); tick();
    lit("order_free1_tag", 32'(ALU_ROB_name), 1);
    dp(6'd7, 4'd5, 0, 32'h55, 1, 4'd15, 0, 0); tick();
    acdb(4'd15, 32'h3); tick(); tick();
`ifdef RS_OLDEST_FIRST_EN
    lit("order_first_tag", 32'(ALU_ROB_name), 4);
`else
    lit("order_first_tag", 32'(ALU_ROB_name), 5);
`endif
    tick();
    lit("order_second_sgn", 32'(ALU_sgn), 1);
    clear = 1; tick();
    tick();
    lit("final_idle", 32'(ALU_sgn), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Tomasulo reservation station that feeds the integer ALU.
- Accepts decoded instructions from dispatch and holds them until both source operands are known.
- Wakes operands by snooping the ALU and LSB common data buses.
- Issues at most one ready instruction per cycle to the ALU via a registered strobe carrying opcode, ROB name, lhs and rhs.

Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32).
- ROB_WIDTH, 4, width of a ROB name (tag).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- rdy  in  1  global ready; low freezes state.
- clear  in  1  ROB misprediction flush.
- DP_sgn  in  1  dispatch valid.
- DP_opcode  in  6  internal opcode code (ADD..STYPE set).
- DP_ROB_name  in  ROB_WIDTH  destination ROB tag.
- DP_Vj, DP_Vk  in  32  operand values, valid when the matching Q*_busy is 0.
- DP_Qj_busy, DP_Qk_busy  in  1  operand still pending.
- DP_Qj, DP_Qk  in  ROB_WIDTH  producer tags of pending operands.
- RS_full  out  1  no free entry.
- ALU_CDB_sgn  in  1  ALU broadcast valid.
- ALU_CDB_ROB_name  in  ROB_WIDTH  ALU broadcast tag.
- ALU_CDB_result  in  32  ALU broadcast value.
- LSB_CDB_sgn  in  1  LSB broadcast valid.
- LSB_CDB_ROB_name  in  ROB_WIDTH  LSB broadcast tag.
- LSB_CDB_result  in  32  LSB broadcast value.
- ALU_sgn  out  1  issue strobe to ALU (registered).
- ALU_opcode  out  6  issued opcode (registered).
- ALU_ROB_name  out  ROB_WIDTH  issued tag (registered).
- ALU_lhs, ALU_rhs  out  32  issued operands (registered).

Behaviour:
- Reset: when rst=0 at an edge, all entries are cleared to not busy and all outputs are driven to 0. RS_full=0.
- Priority at each edge: rst, then clear, then rdy. clear=1 clears every busy bit and ALU_sgn to 0, and drops any dispatch in the same cycle.
- rdy=0 with rst=1 and clear=0:
  - No entry, tag or value changes.
  - ALU_sgn is cleared to 0.
  - The other outputs hold their values.
- Entry fields: busy, opcode, ROB_name, Vj, Vk, Qj_busy, Qj, Qk_busy, Qk.
- Dispatch:
  - On DP_sgn=1 and RS_full=0, the lowest-index free entry is written.
  - DP_sgn while RS_full=1 is ignored. The dispatcher must not rely on this.
- Same-cycle bypass on dispatch: if DP_Q*_busy=1 and a CDB in the same cycle carries a matching tag, the entry stores that result with Q*_busy=0. The ALU CDB wins if both buses match.
- Wakeup: each busy entry with Q*_busy=1 compares against both CDBs every cycle. On a match it captures the result and clears Q*_busy at that edge.
- Ready = busy & !Qj_busy & !Qk_busy, evaluated from the registered entry state only.
  - Wakeup or dispatch in cycle N makes the entry eligible in cycle N+1.
- Issue:
  - Among ready entries, the lowest index is selected.
  - At the edge, busy for that entry is cleared and ALU_sgn=1 with its opcode, tag, Vj→lhs and Vk→rhs.
  - ALU_sgn=0 when nothing is ready.
  - The strobe lasts exactly one cycle per issue.
- Latency: an operands-ready dispatch at edge N gives ALU_sgn=1 after edge N+1.
- RS_full = (busy count == RS_SIZE), combinational from registered busy bits.
  - An entry freed by issue at edge N is reusable from cycle N+1.
  - Dispatch and issue in the same cycle never target the same slot.
- Tags are compared at the full ROB_WIDTH. Tag 0 is a legal tag.

Optional Feature:
RS_OLDEST_FIRST_EN
- Defined:
  - Each entry stores a dispatch sequence number, a wrap-around counter of ROB_WIDTH+1 bits.
  - Issue selects the ready entry whose sequence number is oldest, compared modulo the counter width.
  - The counter is reset by rst and by clear.
- Undefined: lowest-index selection as above, with no sequence storage.

Test Plan:
1. Reset check: hold rst=0 for 2 cycles, then release → ALU_sgn=0 and RS_full=0. One cycle of DP_sgn with no ready operands → no issue.
2. Ready dispatch: ADD, Vj=5, Vk=7, both ready, tag 2, at edge N → after edge N+1: ALU_sgn=1, lhs=5, rhs=7, ROB_name=2. ALU_sgn=0 after edge N+2.
3. Wakeup from CDB: dispatch with Qj=3 pending, Vk=1. Two cycles later ALU_CDB tag 3, result 0x10 → entry woken at that edge; issue after the following edge with lhs=0x10, rhs=1. Repeat via LSB_CDB with the same outcome.
4. Same-cycle bypass: dispatch with Qj=4 pending while LSB_CDB tag 4, result 0xFF is in the same cycle → issue one cycle later with lhs=0xFF.
5. Full and clear:
   - Dispatch 16 entries with Qj=9 pending → RS_full=1; a 17th DP_sgn is ignored.
   - ALU_CDB tag 9 → entries issue one per cycle, lowest index first; RS_full drops after the first issue.
   - clear mid-drain → next cycle ALU_sgn=0 and RS_full=0, with no further issues.
6. rdy freeze: one ready entry, rdy=0 for 3 cycles → ALU_sgn=0 throughout. rdy=1 → issue on the next edge with the original operands. Under RS_OLDEST_FIRST_EN, entries dispatched to indices 3 then 1 → index 3 issues first.
